// File: rtl/instr_seq_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer: fetches instructions, strobes the
// datapath and data memory, resolves jumps/branches from datapath flags, keeps the PC.
module instr_seq_ctrl #(
  parameter int          PC_W       = 5,
  parameter int          IW         = 32,
  parameter int          EXEC_DELAY = 4,
  parameter logic [4:0]  HALT_OP    = 5'b11011
) (
  input  logic            clk,
  input  logic            sys_rst,
  input  logic            start,
  output logic            imem_rd,
  output logic [PC_W-1:0] imem_addr,
  input  logic [IW-1:0]   imem_rdata,
  input  logic            imem_ready,
  output logic [IW-1:0]   ir,
  output logic [PC_W-1:0] pc,
  output logic            exec_en,
  output logic            dm_wr_en,
  output logic            dm_rd_en,
  input  logic            flag_c,
  input  logic            flag_s,
  input  logic            flag_z,
  input  logic            flag_v,
  output logic            illegal,
  output logic            busy,
  output logic            halted
);

  localparam int              CNT_W    = (EXEC_DELAY > 1) ? $clog2(EXEC_DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PC_W-1:0]  PC_ONE   = PC_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WAIT, S_NEXT, S_HALT
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [IW-1:0]    ir_q;
  logic [CNT_W-1:0] cnt_q;
  logic [4:0]       opcode;

  function automatic logic op_undef(input logic [4:0] op);
    return (op == 5'b01100) || (op == 5'b10000) || (op[4:2] == 3'b111);
  endfunction

  function automatic logic op_dm_wr(input logic [4:0] op);
    return (op == 5'b01101) || (op == 5'b01110);
  endfunction

  function automatic logic op_dm_rd(input logic [4:0] op);
    return (op == 5'b01111) || (op == 5'b10001);
  endfunction

  // Non-branch opcodes fall to the default and never redirect the PC.
  function automatic logic branch_taken(input logic [4:0] op, input logic c,
                                        input logic s, input logic z, input logic v);
    case (op)
      5'b10010: return 1'b1;
      5'b10011: return c;
      5'b10100: return ~c;
      5'b10101: return s;
      5'b10110: return ~s;
      5'b10111: return z;
      5'b11000: return ~z;
      5'b11001: return v;
      5'b11010: return ~v;
      default:  return 1'b0;
    endcase
  endfunction

  assign opcode    = ir_q[IW-1 -: 5];
  assign ir        = ir_q;
  assign pc        = pc_q;
  assign imem_addr = pc_q;

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH && imem_ready) ir_q <= imem_rdata;
      if (state_q == S_EXEC)                cnt_q <= '0;
      else if (state_q == S_WAIT)           cnt_q <= cnt_q + CNT_ONE;
      if (state_q == S_NEXT)                pc_q <= pc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    imem_rd  = 1'b0;
    exec_en  = 1'b0;
    dm_wr_en = 1'b0;
    dm_rd_en = 1'b0;
    illegal  = 1'b0;
    busy     = 1'b1;
    halted   = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_rd = 1'b1;
        if (imem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (opcode == HALT_OP) begin
          state_d = S_HALT;
        end else if (op_undef(opcode)) begin
          illegal = 1'b1;
          state_d = S_NEXT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        exec_en  = 1'b1;
        dm_wr_en = op_dm_wr(opcode);
        dm_rd_en = op_dm_rd(opcode);
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == CNT_LAST) state_d = S_NEXT;
      end
      S_NEXT: begin
        pc_d    = branch_taken(opcode, flag_c, flag_s, flag_z, flag_v) ?
                  ir_q[PC_W-1:0] : pc_q + PC_ONE;
        state_d = S_FETCH;
      end
      S_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Bench for instr_seq_ctrl: directed programs plus random instruction streams,
// checked cycle by cycle against an instruction-level reference model.
module tb_instr_seq_ctrl;
  localparam int PC_W = 5;
  localparam int IW   = 32;
  localparam int D    = 4;

  logic            clk = 1'b0;
  logic            sys_rst = 1'b1;
  logic            start = 1'b0;
  logic            imem_rd;
  logic [PC_W-1:0] imem_addr;
  logic [IW-1:0]   imem_rdata = '0;
  logic            imem_ready = 1'b0;
  logic [IW-1:0]   ir;
  logic [PC_W-1:0] pc;
  logic            exec_en, dm_wr_en, dm_rd_en;
  logic            flag_c = 1'b0, flag_s = 1'b0, flag_z = 1'b0, flag_v = 1'b0;
  logic            illegal, busy, halted;

  instr_seq_ctrl #(.PC_W(PC_W), .IW(IW), .EXEC_DELAY(D), .HALT_OP(5'b11011)) dut (
    .clk(clk), .sys_rst(sys_rst), .start(start),
    .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .ir(ir), .pc(pc),
    .exec_en(exec_en), .dm_wr_en(dm_wr_en), .dm_rd_en(dm_rd_en),
    .flag_c(flag_c), .flag_s(flag_s), .flag_z(flag_z), .flag_v(flag_v),
    .illegal(illegal), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [31:0] mem [32];
  int          total = 0, passed = 0, fails = 0, cyc = 0, exec_cyc = 0;
  logic [4:0]  mpc = '0;
  logic [31:0] mir = '0;
  bit          m_halted = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Opcode classes straight from the instruction-set table.
  function automatic bit m_undef(input logic [4:0] op);
    return (op == 12) || (op == 16) || (op >= 28);
  endfunction
  function automatic bit m_wr(input logic [4:0] op);
    return (op == 13) || (op == 14);
  endfunction
  function automatic bit m_rd(input logic [4:0] op);
    return (op == 15) || (op == 17);
  endfunction
  function automatic bit m_br(input logic [4:0] op);
    return (op >= 18) && (op <= 26);
  endfunction
  function automatic bit m_halt(input logic [4:0] op);
    return op == 27;
  endfunction
  // Branches after the unconditional jump come in (flag, not-flag) pairs over c,s,z,v.
  function automatic bit m_taken(input logic [4:0] op, input logic [3:0] fv);
    int k;
    k = int'(op) - 18;
    if (k == 0) return 1'b1;
    return fv[(k - 1) / 2] ^ ((k - 1) % 2 == 1);
  endfunction

  function automatic logic [31:0] enc(input int op, input logic [15:0] tgt);
    logic [10:0] mid;
    mid = 11'($urandom);
    return {5'(op), mid, tgt};
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_pc"}, pc, 0);
    chk({tag, "_ir"}, ir, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_strobes"}, {imem_rd, exec_en, dm_wr_en, dm_rd_en, illegal}, 0);
  endtask

  task automatic do_reset(input string tag);
    sys_rst = 1'b1;
    #1;
    chk_reset(tag);
    step();
    step();
    sys_rst = 1'b0;
    mpc = '0;
    mir = '0;
    m_halted = 1'b0;
    step();
    chk({tag, "_idle_busy"}, busy, 0);
  endtask

  task automatic begin_run();
    start = 1'b1;
    cyc = 0;
    step();
    start = 1'b0;
  endtask

  // Entered with the DUT in FETCH; leaves it in the next FETCH (or HALT).
  task automatic run_instr(input int dly, input logic [3:0] fv);
    logic [31:0] w;
    logic [4:0]  op;
    chk("fetch_pc", pc, mpc);
    chk("fetch_addr", imem_addr, mpc);
    chk("fetch_rd", imem_rd, 1);
    chk("fetch_busy", busy, 1);
    for (int i = 0; i < dly; i++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      step();
      chk("stall_rd", imem_rd, 1);
      chk("stall_ir", ir, mir);
    end
    w = mem[mpc];
    op = w[31:27];
    imem_rdata = w;
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    mir = w;
    chk("dec_ir", ir, w);
    chk("dec_rd", imem_rd, 0);
    chk("dec_illegal", illegal, m_undef(op));
    chk("dec_exec", exec_en, 0);
    if (m_halt(op)) begin
      step();
      chk("halt_halted", halted, 1);
      chk("halt_busy", busy, 0);
      chk("halt_pc", pc, mpc);
      m_halted = 1'b1;
      return;
    end
    if (!m_undef(op)) begin
      step();
      exec_cyc = cyc;
      chk("exec_en", exec_en, 1);
      chk("exec_wr", dm_wr_en, m_wr(op));
      chk("exec_rd", dm_rd_en, m_rd(op));
      for (int i = 0; i < D; i++) begin
        {flag_v, flag_z, flag_s, flag_c} = 4'($urandom);
        step();
        chk("wait_exec", exec_en, 0);
        chk("wait_dm", dm_wr_en | dm_rd_en, 0);
        chk("wait_ir", ir, w);
      end
    end
    {flag_v, flag_z, flag_s, flag_c} = fv;
    step();
    chk("next_exec", exec_en, 0);
    chk("next_illegal", illegal, 0);
    chk("next_pc", pc, mpc);
    chk("next_ir", ir, w);
    if (m_br(op) && m_taken(op, fv)) mpc = w[PC_W-1:0];
    else mpc = mpc + 5'd1;
    step();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = enc(0, 16'($urandom));
    do_reset("por");

    // Straight line, memory ops, branches, illegal opcode, wrap.
    mem[0]  = enc(1, 16'($urandom));
    mem[1]  = enc(2, 16'($urandom));
    mem[2]  = enc(3, 16'($urandom));
    mem[3]  = enc(0, 16'($urandom));
    mem[4]  = enc(13, 16'($urandom));
    mem[5]  = enc(17, 16'($urandom));
    mem[6]  = enc(23, 16'd9);
    mem[9]  = enc(23, 16'd20);
    mem[10] = enc(20, 16'd3);
    mem[11] = enc(12, 16'($urandom));
    mem[12] = enc(18, 16'h0025);
    mem[7]  = enc(18, 16'd31);
    mem[31] = enc(1, 16'($urandom));
    begin_run();
    run_instr(0, 4'b0000);
    chk("exec_cyc_0", exec_cyc, 3);
    run_instr(0, 4'b0000);
    chk("exec_cyc_1", exec_cyc, 11);
    run_instr(0, 4'b0000);
    chk("exec_cyc_2", exec_cyc, 19);
    run_instr(3, 4'b0000);
    run_instr(0, 4'b0000);
    run_instr(0, 4'b0000);
    run_instr(0, 4'b0100);
    chk("jzero_taken_pc", pc, 9);
    run_instr(0, 4'b0000);
    chk("jzero_not_pc", pc, 10);
    run_instr(0, 4'b0001);
    chk("jnocarry_not_pc", pc, 11);
    run_instr(0, 4'b1111);
    chk("illegal_next_pc", pc, 12);
    run_instr(0, 4'b0000);
    chk("jump_trunc_pc", pc, 5);
    run_instr(1, 4'b0000);
    run_instr(0, 4'b1011);
    run_instr(2, 4'b0000);
    chk("jump31_pc", pc, 31);
    run_instr(0, 4'b1111);
    chk("wrap_pc", pc, 0);

    // Reset in WAIT and during the exec strobe.
    run_instr(0, 4'b0000);
    imem_rdata = mem[1];
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    step();
    chk("pre_rst_exec", exec_en, 1);
    step();
    step();
    do_reset("rst_wait");
    begin_run();
    run_instr(0, 4'b0000);
    imem_rdata = mem[1];
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    step();
    chk("pre_rst_strobe", exec_en, 1);
    do_reset("rst_exec");

    // Halt at pc 6; start pulses must be ignored.
    for (int i = 0; i < 6; i++) mem[i] = enc($urandom_range(0, 11), 16'($urandom));
    mem[6] = enc(27, 16'($urandom));
    begin_run();
    for (int i = 0; i < 7; i++) run_instr(0, 4'($urandom));
    chk("halt_seen", m_halted, 1);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      chk("halt_hold", halted, 1);
      chk("halt_hold_pc", pc, 6);
      chk("halt_hold_busy", {busy, imem_rd, exec_en}, 0);
    end
    do_reset("rst_halt");

    // Random instruction streams.
    for (int i = 0; i < 32; i++) begin
      int op;
      op = $urandom_range(0, 31);
      if (op == 27 && ($urandom % 4) != 0) op = 1;
      mem[i] = enc(op, 16'($urandom));
    end
    begin_run();
    for (int n = 0; n < 150; n++) begin
      if (m_halted) begin
        start = 1'b1;
        step();
        start = 1'b0;
        chk("rand_halt_hold", halted, 1);
        do_reset("rand_rst");
        begin_run();
      end else begin
        run_instr($urandom_range(0, 3), 4'($urandom));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
